fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS. Sits directly upstream of the IF/ID pipeline register. Owns the PC and runs a one-outstanding-request handshake to instruction memory. Produces the instruction word, PC+4 and the IF/ID write enable that the IF/ID register samples on the next Clk edge. Also handles load-use stalls from the hazard unit and branch/jump redirects from ID, including flush-to-NOP.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and runs a one-outstanding-request handshake to instruction memory.
// Presents the fetched word, PC+4 and the IF/ID write enable; handles load-use stalls and branch/jump flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        IF_IDWrite
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_hold_instr;
  logic [XLEN-1:0]   r_redirect_pc;

  state_t            w_state_next;
  logic [XLEN-1:0]   w_pc_next;
  logic [XLEN-1:0]   w_hold_next;
  logic [XLEN-1:0]   w_redirect_pc_next;
  logic              w_req;
  logic              w_wr;
  logic [XLEN-1:0]   w_instr;
  logic              w_redirect;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_inc;

  // Branch wins over jump; low address bits are dropped to keep fetches word aligned.
  assign w_redirect = branch_taken | jump;
  assign w_target   = (branch_taken ? branch_target : jump_target) & ~XLEN'(3);
  assign w_pc_inc   = r_pc + XLEN'(4);

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_hold_next        = r_hold_instr;
    w_redirect_pc_next = r_redirect_pc;
    w_req              = 1'b0;
    w_wr               = 1'b0;
    w_instr            = NOP_WORD;
    unique case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (w_redirect) begin
            w_wr      = 1'b1;
            w_pc_next = w_target;
          end else if (PCWrite) begin
            w_instr   = imem_rdata;
            w_wr      = 1'b1;
            w_pc_next = w_pc_inc;
          end else begin
            w_hold_next  = imem_rdata;
            w_state_next = S_HOLD;
          end
        end else if (w_redirect) begin
          // Address must stay put until memory answers, so park the target and drain.
          w_wr               = 1'b1;
          w_redirect_pc_next = w_target;
          w_state_next       = S_DRAIN;
        end else begin
          w_wr = PCWrite;
        end
      end
      S_HOLD: begin
        w_instr = r_hold_instr;
        if (w_redirect) begin
          w_instr      = NOP_WORD;
          w_wr         = 1'b1;
          w_pc_next    = w_target;
          w_state_next = S_FETCH;
        end else if (PCWrite) begin
          w_wr         = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = S_FETCH;
        end
      end
      S_DRAIN: begin
        w_req = 1'b1;
        w_wr  = PCWrite;
        if (imem_ready) begin
          w_pc_next    = w_redirect ? w_target : r_redirect_pc;
          w_state_next = S_FETCH;
        end else if (w_redirect) begin
          w_redirect_pc_next = w_target;
        end
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_hold_instr  <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_hold_instr  <= w_hold_next;
      r_redirect_pc <= w_redirect_pc_next;
    end
  end

  // Reset squashes the request and the IF/ID write immediately, without waiting for an edge.
  assign imem_req    = w_req & ~rst;
  assign imem_addr   = r_pc;
  assign pc_plus4    = w_pc_inc;
  assign instruction = rst ? NOP_WORD : w_instr;
  assign IF_IDWrite  = w_wr & ~rst;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random stall/redirect/ready traffic
// checked against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        IF_IDWrite;

  always #5 Clk = ~Clk;

  // Memory: each word is the complement of its address; garbage when not ready.
  assign imem_rdata = imem_ready ? ~imem_addr : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .Clk(Clk), .rst(rst), .PCWrite(PCWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_plus4(pc_plus4), .IF_IDWrite(IF_IDWrite)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        chk_instr;
    logic [31:0] instr;
    logic [31:0] pp4;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: the address to fetch next, an optional parked word, an optional pending redirect.
  logic [31:0] m_pc = RESET_PC;
  bit          m_held = 1'b0;
  logic [31:0] m_held_word = '0;
  bit          m_drain = 1'b0;
  logic [31:0] m_drain_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic model_cycle(input bit pcw, input bit bt, input logic [31:0] btgt,
                             input bit j, input logic [31:0] jtgt, input bit rdy);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    redir       = bt | j;
    tgt         = bt ? btgt : jtgt;
    tgt[1:0]    = 2'b00;
    e.addr      = m_pc;
    e.pp4       = m_pc + 32'd4;
    e.instr     = NOP_WORD;
    e.chk_instr = 1'b1;
    if (m_held) begin
      e.req   = 1'b0;
      e.wr    = redir | pcw;
      e.instr = redir ? NOP_WORD : m_held_word;
      if (redir) begin
        m_pc = tgt; m_held = 1'b0;
      end else if (pcw) begin
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else if (m_drain) begin
      e.req = 1'b1;
      e.wr  = pcw;
      if (rdy) begin
        m_pc = redir ? tgt : m_drain_pc; m_drain = 1'b0;
      end else if (redir) begin
        m_drain_pc = tgt;
      end
    end else begin
      e.req = 1'b1;
      if (rdy && redir) begin
        e.wr = 1'b1; m_pc = tgt;
      end else if (rdy && pcw) begin
        e.wr = 1'b1; e.instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        e.wr = 1'b0; e.chk_instr = 1'b0; m_held = 1'b1; m_held_word = mem_word(m_pc);
      end else if (redir) begin
        e.wr = 1'b1; m_drain = 1'b1; m_drain_pc = tgt;
      end else begin
        e.wr = pcw;
      end
    end
    sb.push_back(e);
  endtask

  task automatic step(input bit pcw, input bit bt, input logic [31:0] btgt,
                      input bit j, input logic [31:0] jtgt, input bit rdy);
    @(posedge Clk);
    #1;
    rst = 1'b0; PCWrite = pcw; branch_taken = bt; branch_target = btgt;
    jump = j; jump_target = jtgt; imem_ready = rdy;
    model_cycle(pcw, bt, btgt, j, jtgt, rdy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  // Reset asserted dly time units after a rising edge, with the other inputs idle.
  task automatic reset_cycle(input int dly);
    exp_t e;
    @(posedge Clk);
    #1;
    PCWrite = 1'b1; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    #(dly);
    rst = 1'b1;
    e.req = 1'b0; e.addr = '0; e.wr = 1'b0; e.chk_instr = 1'b1; e.instr = NOP_WORD; e.pp4 = '0;
    sb.push_back(e);
    m_pc = RESET_PC; m_held = 1'b0; m_drain = 1'b0;
  endtask

  exp_t mon_e;
  bit   mon_bad;
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_bad = 1'b0;
      n_vec++;
      if (imem_req !== mon_e.req) begin
        mon_bad = 1'b1;
        $display("FAIL imem_req vec %0d: got %b want %b", n_vec, imem_req, mon_e.req);
      end
      if (mon_e.req && imem_addr !== mon_e.addr) begin
        mon_bad = 1'b1;
        $display("FAIL imem_addr vec %0d: got %h want %h", n_vec, imem_addr, mon_e.addr);
      end
      if (IF_IDWrite !== mon_e.wr) begin
        mon_bad = 1'b1;
        $display("FAIL IF_IDWrite vec %0d: got %b want %b", n_vec, IF_IDWrite, mon_e.wr);
      end
      if (mon_e.chk_instr && instruction !== mon_e.instr) begin
        mon_bad = 1'b1;
        $display("FAIL instruction vec %0d: got %h want %h", n_vec, instruction, mon_e.instr);
      end
      if (mon_e.wr && pc_plus4 !== mon_e.pp4) begin
        mon_bad = 1'b1;
        $display("FAIL pc_plus4 vec %0d: got %h want %h", n_vec, pc_plus4, mon_e.pp4);
      end
      if (mon_bad) n_bad++;
    end
  end

  initial begin
    bit          pcw, bt, j, rdy;
    logic [31:0] btgt, jtgt;
    reset_cycle(1);
    reset_cycle(1);
    // Sequential fetch from reset, then a two-cycle stall at address 8.
    run(2);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    run(1);
    // Branch flush with misaligned target, then branch beating a simultaneous jump.
    step(1'b1, 1'b1, 32'h0000_0043, 1'b0, '0, 1'b1);
    run(1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1);
    run(1);
    // Redirect while memory is busy at address 20.
    step(1'b1, 1'b0, '0, 1'b1, 32'h0000_0014, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    run(1);
    // PC wrap at the top of the address space.
    step(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    run(2);
    // Asynchronous reset in the middle of a drain.
    step(1'b1, 1'b0, '0, 1'b1, 32'h0000_0080, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    reset_cycle(3);
    reset_cycle(1);
    run(2);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        reset_cycle($urandom_range(3, 1));
      end else begin
        pcw  = ($urandom_range(9) < 8);
        bt   = ($urandom_range(9) == 0);
        j    = ($urandom_range(9) == 0);
        rdy  = ($urandom_range(9) < 7);
        btgt = $urandom;
        jtgt = $urandom;
        step(pcw, bt, btgt, j, jtgt, rdy);
      end
    end
    repeat (2) @(negedge Clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
